// File: rtl/mac_requant_relu.sv
`default_nettype none
// ============================================================================
// Module      : mac_requant_relu
// Description : Output stage behind the signed 16-bit MAC. It takes finished
//               accumulator words, adds a per-word bias, and requantizes the
//               result to int8. Requantization is an arithmetic right shift
//               with round-half-up, followed by optional ReLU and then
//               saturation.
//               The block is a two-stage elastic pipeline with valid/ready
//               on both sides and full backpressure. It sustains one word
//               per cycle when out_ready is held high.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   accumulator word valid
//   in_ready   out  stage 1 can accept a word this cycle
//   in_acc     in   signed accumulator (ACC_W)
//   cfg_bias   in   signed bias, sampled with in_acc (ACC_W)
//   cfg_shift  in   right-shift amount, sampled with in_acc (SHIFT_W)
//   cfg_relu   in   clamp negatives to zero, sampled with in_acc
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   out_data   out  signed requantized result (OUT_W)
//   sat_clr    in   synchronous clear of sat_cnt
//   sat_cnt    out  count of saturated results (CNT_W)
// Build option:
//   MAC_REQUANT_SAT_CNT_EN - when defined, the saturation event counter is
//   built. When undefined, sat_cnt reads 0 and sat_clr is ignored.
// ============================================================================
module mac_requant_relu #(
    parameter int ACC_W   = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   in_acc,
    input  logic [ACC_W-1:0]   cfg_bias,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_relu,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    input  logic               sat_clr,
    output logic [CNT_W-1:0]   sat_cnt
);

    // The rounding and shift work is done at ACC_W+2 bits. The biased sum
    // needs ACC_W+1 bits. Adding the rounding constant can exceed that width
    // when the shift is large, so one extra bit of headroom is kept.
    localparam int                      c_MAX_INT = (1 << (OUT_W - 1)) - 1;
    localparam int                      c_MIN_INT = -(1 << (OUT_W - 1));
    localparam logic signed [ACC_W+1:0] c_SAT_MAX = (ACC_W + 2)'(c_MAX_INT);
    localparam logic signed [ACC_W+1:0] c_SAT_MIN = (ACC_W + 2)'(c_MIN_INT);
    localparam logic        [ACC_W+1:0] c_ONE     = (ACC_W + 2)'(1);

    // Stage 1 holds the biased sum and its per-word configuration.
    logic                      r_s1_valid;
    logic signed [ACC_W:0]     r_s1_sum;
    logic        [SHIFT_W-1:0] r_s1_shift;
    logic                      r_s1_relu;

    // Stage 2 is the output register.
    logic                      r_out_valid;
    logic        [OUT_W-1:0]   r_out_data;

    logic                      w_s2_load;
    logic                      w_in_xfer;
    logic signed [ACC_W+1:0]   w_ext;
    logic signed [ACC_W+1:0]   w_rnd;
    logic signed [ACC_W+1:0]   w_sum_rnd;
    logic signed [ACC_W+1:0]   w_shifted;
    logic signed [ACC_W+1:0]   w_relu;
    logic        [OUT_W-1:0]   w_sat_data;
    logic                      w_sat;

    // Stage 2 can take a word whenever it is empty or is being drained in
    // this same cycle. Stage 1 can then refill behind it, which keeps the
    // pipeline at full rate.
    assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_in_xfer = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_shift <= '0;
            r_s1_relu  <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_sum   <= {in_acc[ACC_W-1], in_acc} + {cfg_bias[ACC_W-1], cfg_bias};
            r_s1_shift <= cfg_shift;
            r_s1_relu  <= cfg_relu;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Round half up: add 2^(shift-1) before the arithmetic shift. A shift
    // of zero has no rounding term.
    assign w_ext     = {r_s1_sum[ACC_W], r_s1_sum};
    assign w_rnd     = (r_s1_shift == '0) ? '0
                     : (c_ONE << (r_s1_shift - SHIFT_W'(1)));
    assign w_sum_rnd = w_ext + w_rnd;
    assign w_shifted = w_sum_rnd >>> r_s1_shift;

    // The ReLU clamp is applied before saturation. A negative value clamped
    // to zero therefore never counts as a saturation event.
    assign w_relu = (r_s1_relu && w_shifted[ACC_W+1]) ? '0 : w_shifted;

    always_comb begin
        w_sat_data = w_relu[OUT_W-1:0];
        w_sat      = 1'b0;
        if (w_relu > c_SAT_MAX) begin
            w_sat_data = c_SAT_MAX[OUT_W-1:0];
            w_sat      = 1'b1;
        end else if (w_relu < c_SAT_MIN) begin
            w_sat_data = c_SAT_MIN[OUT_W-1:0];
            w_sat      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sat_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef MAC_REQUANT_SAT_CNT_EN
    // The counter sticks at all-ones instead of wrapping. A clear takes
    // priority over an increment in the same cycle.
    logic [CNT_W-1:0] r_sat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (w_s2_load && w_sat && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
        end
    end

    assign sat_cnt = r_sat_cnt;
`else
    // Without the counter, the clear input and the saturation flag have no
    // consumer. They are gathered here so that they are visibly terminated.
    logic w_unused_sat;

    assign w_unused_sat = sat_clr ^ w_sat;
    assign sat_cnt      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_requant_relu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_requant_relu
// Description : Directed self-checking bench for mac_requant_relu. It covers
//               reset state, rounding, ReLU, saturation and the saturation
//               counter, backpressure streaming, and reset while words are in
//               flight. Every expected value is computed by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_requant_relu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_acc;
    logic [15:0] cfg_bias;
    logic [3:0]  cfg_shift;
    logic        cfg_relu;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        sat_clr;
    logic [15:0] sat_cnt;

    int n_checks;
    int n_fail;

    mac_requant_relu #(
        .ACC_W   (16),
        .OUT_W   (8),
        .SHIFT_W (4),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .cfg_bias  (cfg_bias),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    // Gives the expected counter value for the current build. Without the
    // counter option, sat_cnt always reads zero.
    function automatic int ec(input int n);
`ifdef MAC_REQUANT_SAT_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one word with out_ready held high. It checks the two-cycle
    // latency, the result and the counter. When clr is set, sat_clr is
    // pulsed in the cycle in which stage 2 loads this word.
    task automatic send(input string tag, input logic [15:0] acc, input logic [15:0] bias,
                        input logic [3:0] sh, input logic relu, input logic clr,
                        input logic [7:0] exp_data, input int exp_cnt);
        @(negedge clk);
        in_valid  = 1'b1;
        in_acc    = acc;
        cfg_bias  = bias;
        cfg_shift = sh;
        cfg_relu  = relu;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        sat_clr  = clr;
        chk({tag, ".lat1_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        sat_clr = 1'b0;
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".data"}, 32'(out_data), 32'(exp_data));
        chk({tag, ".sat_cnt"}, 32'(sat_cnt), 32'(exp_cnt));
    endtask

    initial begin
        int acc_cnt;
        int del_cnt;
        logic prev_stall;
        logic [7:0] prev_data;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_acc    = '0;
        cfg_bias  = '0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.sat_cnt", 32'(sat_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // (300 + 2) >>> 2 = 75.
        send("round", 16'd300, 16'd0, 4'd2, 1'b0, 1'b0, 8'd75, ec(0));
        // (-7 + 1) >>> 1 = -3.
        send("neg_round", -16'sd7, 16'd0, 4'd1, 1'b0, 1'b0, 8'hFD, ec(0));
        send("relu_on", -16'sd50, 16'd0, 4'd0, 1'b1, 1'b0, 8'h00, ec(0));
        send("relu_off", -16'sd50, 16'd0, 4'd0, 1'b0, 1'b0, 8'hCE, ec(0));
        // 32767 + 32767 = 65534 clamps to 127.
        send("pos_sat", 16'h7FFF, 16'h7FFF, 4'd0, 1'b0, 1'b0, 8'h7F, ec(1));
        // -65536 clamps to -128.
        send("neg_sat", 16'h8000, 16'h8000, 4'd0, 1'b0, 1'b0, 8'h80, ec(2));
        // Maximum shift: (-65536 + 16384) >>> 15 = -2.
        send("shift15_neg", 16'h8000, 16'h8000, 4'd15, 1'b0, 1'b0, 8'hFE, ec(2));
        // Maximum shift: (65534 + 16384) >>> 15 = 2.
        send("shift15_pos", 16'h7FFF, 16'h7FFF, 4'd15, 1'b0, 1'b0, 8'h02, ec(2));
        send("sat3", 16'h7FFF, 16'h7FFF, 4'd0, 1'b0, 1'b0, 8'h7F, ec(3));
        send("sat4", 16'h7FFF, 16'h7FFF, 4'd0, 1'b0, 1'b0, 8'h7F, ec(4));
        send("sat5", 16'h7FFF, 16'h7FFF, 4'd0, 1'b0, 1'b0, 8'h7F, ec(5));
        // A clear in the same cycle as a saturating load wins.
        send("sat_clr", 16'h7FFF, 16'h7FFF, 4'd0, 1'b0, 1'b1, 8'h7F, ec(0));
        send("sat_after_clr", 16'h8000, 16'h8000, 4'd0, 1'b0, 1'b0, 8'h80, ec(1));

        // Backpressure. The words are k*4 with shift 2, so each result is k.
        // out_ready follows the repeating pattern 1, 0, 0.
        acc_cnt    = 0;
        del_cnt    = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        cfg_bias   = '0;
        cfg_shift  = 4'd2;
        cfg_relu   = 1'b0;
        for (int cyc = 0; cyc < 200 && del_cnt < 10; cyc++) begin
            @(negedge clk);
            out_ready = (cyc % 3 == 0);
            in_valid  = (acc_cnt < 10);
            in_acc    = 16'(acc_cnt * 4);
            #1;
            if (prev_stall) begin
                chk("bp.hold_valid", 32'(out_valid), 32'd1);
                chk("bp.hold_data", 32'(out_data), 32'(prev_data));
            end
            if ((acc_cnt - del_cnt) == 2 && !out_ready)
                chk("bp.in_ready_full", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                chk("bp.data", 32'(out_data), 32'(del_cnt));
                del_cnt++;
            end
            if (in_valid && in_ready)
                acc_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        chk("bp.delivered", 32'(del_cnt), 32'd10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.drained", 32'(out_valid), 32'd0);

        // Reset with two words in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_acc    = 16'd100;
        cfg_shift = 4'd0;
        @(negedge clk);
        in_acc = 16'd200;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid.valid_before", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.valid_async", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid.valid_after", 32'(out_valid), 32'd0);
        // (16 + 8) >>> 4 = 1.
        send("post_rst", 16'd16, 16'd0, 4'd4, 1'b0, 1'b0, 8'd1, ec(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
